// File: rtl/ts_injection_scheduler_if.sv
// TS injection request handshake between the slot scheduler
// and the TS injection management block.
interface ts_injection_scheduler_if;
    logic [4:0] ts_injection_addr;
    logic       ts_injection_addr_wr;
    logic       ts_injection_addr_ack;

    modport master (
        output ts_injection_addr,
        output ts_injection_addr_wr,
        input  ts_injection_addr_ack
    );

    modport slave (
        input  ts_injection_addr,
        input  ts_injection_addr_wr,
        output ts_injection_addr_ack
    );
endinterface

// File: rtl/ts_injection_scheduler.sv
// Time-slot scheduler: walks a host-written slot table and raises one
// held injection request per valid slot, counting slots it had to skip.
module ts_injection_scheduler #(
    parameter int TBL_AW = 5,
    parameter int SLOT_W = 12
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_sched_en,
    input  logic [SLOT_W-1:0]     iv_slot_len,
    input  logic [TBL_AW:0]       iv_table_len,
    input  logic                  i_cfg_wr,
    input  logic [TBL_AW-1:0]     iv_cfg_waddr,
    input  logic [5:0]            iv_cfg_wdata,
    ts_injection_scheduler_if.master inj,
    output logic [TBL_AW-1:0]     ov_slot_idx,
    output logic                  o_slot_pulse,
    output logic                  o_cycle_pulse,
    output logic                  o_injection_miss_pulse,
    output logic [15:0]           ov_miss_cnt
);
    localparam int DEPTH = 1 << TBL_AW;
    localparam logic [TBL_AW:0] DEPTH_W = (TBL_AW+1)'(DEPTH);
    localparam logic [SLOT_W-1:0] MIN_LEN = SLOT_W'(4);

    typedef enum logic {IDLE, REQ} state_e;

    state_e state_q, state_d;

    logic [5:0]        tbl_q [DEPTH];
    logic [5:0]        tbl_d [DEPTH];
    logic [SLOT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [TBL_AW-1:0] slot_idx_q, slot_idx_d;
    logic [4:0]        addr_q, addr_d;
    logic              slot_pulse_q, slot_pulse_d;
    logic              cycle_pulse_q, cycle_pulse_d;
    logic              miss_pulse_q, miss_pulse_d;
    logic [15:0]       miss_cnt_q, miss_cnt_d;

    logic [SLOT_W-1:0] eff_len;
    logic [TBL_AW:0]   eff_tlen;
    logic [5:0]        entry;
    logic              boundary, ent_valid, pending, ack_done;
    logic              issue, miss;

    always_comb begin
        eff_len = (iv_slot_len < MIN_LEN) ? MIN_LEN : iv_slot_len;
        eff_tlen = iv_table_len;
        if (iv_table_len == '0 || iv_table_len > DEPTH_W) begin
            eff_tlen = DEPTH_W;
        end
        entry     = tbl_q[slot_idx_q];
        boundary  = i_sched_en && (cycle_cnt_q == '0);
        ent_valid = boundary && entry[5];
        // an ack arriving with the boundary frees the slot for the new flow
        pending   = (state_q == REQ) && !inj.ts_injection_addr_ack;
        ack_done  = (state_q == REQ) && inj.ts_injection_addr_ack;
        issue     = ent_valid && !pending;
        miss      = ent_valid && pending;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!i_sched_en) begin
            state_d = IDLE;
        end else if (issue) begin
            state_d = REQ;
        end else if (ack_done) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        inj.ts_injection_addr_wr = (state_q == REQ);
        inj.ts_injection_addr    = addr_q;
    end

    always_comb begin
        tbl_d = tbl_q;
        if (i_cfg_wr) begin
            tbl_d[iv_cfg_waddr] = iv_cfg_wdata;
        end
        cycle_cnt_d   = '0;
        slot_idx_d    = '0;
        slot_pulse_d  = 1'b0;
        cycle_pulse_d = 1'b0;
        miss_pulse_d  = 1'b0;
        addr_d        = issue ? entry[4:0] : addr_q;
        miss_cnt_d    = miss_cnt_q;
        if (miss && miss_cnt_q != 16'hFFFF) begin
            miss_cnt_d = miss_cnt_q + 16'd1;
        end
        if (i_sched_en) begin
            slot_pulse_d  = boundary;
            cycle_pulse_d = boundary && (slot_idx_q == '0);
            miss_pulse_d  = miss;
            // >= so a live shrink of either length wraps instead of running on
            if (cycle_cnt_q >= eff_len - SLOT_W'(1)) begin
                cycle_cnt_d = '0;
                if ({1'b0, slot_idx_q} >= eff_tlen - (TBL_AW+1)'(1)) begin
                    slot_idx_d = '0;
                end else begin
                    slot_idx_d = slot_idx_q + TBL_AW'(1);
                end
            end else begin
                cycle_cnt_d = cycle_cnt_q + SLOT_W'(1);
                slot_idx_d  = slot_idx_q;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tbl_q         <= '{default: '0};
            cycle_cnt_q   <= '0;
            slot_idx_q    <= '0;
            addr_q        <= '0;
            slot_pulse_q  <= 1'b0;
            cycle_pulse_q <= 1'b0;
            miss_pulse_q  <= 1'b0;
            miss_cnt_q    <= '0;
        end else begin
            tbl_q         <= tbl_d;
            cycle_cnt_q   <= cycle_cnt_d;
            slot_idx_q    <= slot_idx_d;
            addr_q        <= addr_d;
            slot_pulse_q  <= slot_pulse_d;
            cycle_pulse_q <= cycle_pulse_d;
            miss_pulse_q  <= miss_pulse_d;
            miss_cnt_q    <= miss_cnt_d;
        end
    end

    assign ov_slot_idx            = slot_idx_q;
    assign o_slot_pulse           = slot_pulse_q;
    assign o_cycle_pulse          = cycle_pulse_q;
    assign o_injection_miss_pulse = miss_pulse_q;
    assign ov_miss_cnt            = miss_cnt_q;
endmodule

// File: tb/tb_ts_injection_scheduler.sv
// Bench for ts_injection_scheduler: slot-arithmetic reference model
// compared every cycle, plus directed literal expectations.
module tb_ts_injection_scheduler;
    localparam int AW = 5;
    localparam int SW = 12;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic [SW-1:0] slot_len = 12'd10;
    logic [AW:0]   table_len = 6'd4;
    logic          cfg_wr = 1'b0;
    logic [AW-1:0] waddr = '0;
    logic [5:0]    wdata = '0;
    logic [AW-1:0] slot_idx;
    logic          slot_p, cyc_p, miss_p;
    logic [15:0]   miss_cnt;

    ts_injection_scheduler_if inj ();

    ts_injection_scheduler #(.TBL_AW(AW), .SLOT_W(SW)) dut (
        .i_clk                  (clk),
        .i_rst_n                (rst_n),
        .i_sched_en             (en),
        .iv_slot_len            (slot_len),
        .iv_table_len           (table_len),
        .i_cfg_wr               (cfg_wr),
        .iv_cfg_waddr           (waddr),
        .iv_cfg_wdata           (wdata),
        .inj                    (inj),
        .ov_slot_idx            (slot_idx),
        .o_slot_pulse           (slot_p),
        .o_cycle_pulse          (cyc_p),
        .o_injection_miss_pulse (miss_p),
        .ov_miss_cnt            (miss_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // reference model: position k since enable decides slot and boundary
    int         k = -1;
    bit         pend = 0;
    logic [4:0] m_addr = '0;
    int         m_miss = 0;
    logic [5:0] mt [DEPTH];
    bit         e_slot, e_cyc, e_miss;
    int         e_idx = 0;

    always @(posedge clk) begin
        int L, T, s;
        logic [5:0] e;
        bit ack, bv;
        ack = inj.ts_injection_addr_ack;
        L = (slot_len < 4) ? 4 : int'(slot_len);
        T = (table_len == 0 || table_len > DEPTH) ? DEPTH : int'(table_len);
        e_slot = 0;
        e_cyc = 0;
        e_miss = 0;
        if (!rst_n) begin
            k = -1;
            pend = 0;
            m_addr = '0;
            m_miss = 0;
            e_idx = 0;
            foreach (mt[i]) mt[i] = '0;
        end else begin
            if (!en) begin
                k = -1;
                pend = 0;
                e_idx = 0;
            end else begin
                k++;
                s = (k / L) % T;
                e = mt[s];
                bv = (k % L == 0) && e[5];
                if (k % L == 0) begin
                    e_slot = 1;
                    e_cyc = (s == 0);
                end
                if (bv && !(pend && !ack)) begin
                    pend = 1;
                    m_addr = e[4:0];
                end else if (bv) begin
                    e_miss = 1;
                    if (m_miss < 65535) m_miss++;
                end else if (pend && ack) begin
                    pend = 0;
                end
                e_idx = ((k + 1) / L) % T;
            end
            if (cfg_wr) mt[waddr] = wdata;
        end
        #1;
        chk("wr", 32'(inj.ts_injection_addr_wr), 32'(pend));
        chk("slot_pulse", 32'(slot_p), 32'(e_slot));
        chk("cycle_pulse", 32'(cyc_p), 32'(e_cyc));
        chk("miss_pulse", 32'(miss_p), 32'(e_miss));
        chk("slot_idx", 32'(slot_idx), 32'(e_idx));
        chk("miss_cnt", 32'(miss_cnt), 32'(m_miss));
        if (pend) chk("addr", 32'(inj.ts_injection_addr), 32'(m_addr));
    end

    // stimulus
    int         ack_mode = 0;
    bit         rnd_cfg = 0;
    bit         rnd_en = 0;
    bit         wr_prev = 0;
    int         n_rise, n_slot, n_cyc, n_miss;
    logic [4:0] rises [$];

    task automatic clr();
        n_rise = 0;
        n_slot = 0;
        n_cyc = 0;
        n_miss = 0;
        rises.delete();
    endtask

    task automatic step(int n);
        repeat (n) begin
            @(negedge clk);
            if (inj.ts_injection_addr_wr && !wr_prev) begin
                n_rise++;
                rises.push_back(inj.ts_injection_addr);
            end
            wr_prev = inj.ts_injection_addr_wr;
            n_slot += int'(slot_p);
            n_cyc += int'(cyc_p);
            n_miss += int'(miss_p);
            case (ack_mode)
                1: inj.ts_injection_addr_ack = inj.ts_injection_addr_wr;
                2: inj.ts_injection_addr_ack = ($urandom % 3 == 0);
                default: ;
            endcase
            if (rnd_cfg) begin
                cfg_wr = ($urandom % 4 == 0);
                waddr = AW'($urandom);
                wdata = 6'($urandom);
            end
            if (rnd_en) en = ($urandom % 60 != 0);
        end
    endtask

    task automatic wr_cfg(logic [AW-1:0] a, logic [5:0] d);
        cfg_wr = 1'b1;
        waddr = a;
        wdata = d;
        step(1);
        cfg_wr = 1'b0;
    endtask

    task automatic halt();
        en = 1'b0;
        inj.ts_injection_addr_ack = 1'b0;
        step(2);
        clr();
    endtask

    initial begin
        inj.ts_injection_addr_ack = 1'b0;
        clr();
        step(2);
        chk("rst_wr", 32'(inj.ts_injection_addr_wr), 0);
        chk("rst_addr", 32'(inj.ts_injection_addr), 0);
        chk("rst_miss", 32'(miss_cnt), 0);
        rst_n = 1'b1;
        step(1);

        // basic rotation with prompt acks
        wr_cfg(0, 6'h25);
        wr_cfg(1, 6'h29);
        wr_cfg(2, 6'h3F);
        wr_cfg(3, 6'h22);
        clr();
        ack_mode = 1;
        en = 1'b1;
        step(80);
        chk("t1_rises", 32'(rises.size() >= 5), 1);
        if (rises.size() >= 5) begin
            chk("t1_a0", 32'(rises[0]), 5);
            chk("t1_a1", 32'(rises[1]), 9);
            chk("t1_a2", 32'(rises[2]), 31);
            chk("t1_a3", 32'(rises[3]), 2);
            chk("t1_a4", 32'(rises[4]), 5);
        end
        chk("t1_cyc", 32'(n_cyc), 2);
        chk("t1_slots", 32'(n_slot), 8);
        chk("t1_miss", 32'(miss_cnt), 0);

        // invalid entry 1
        halt();
        wr_cfg(1, 6'h09);
        clr();
        slot_len = 12'd8;
        en = 1'b1;
        step(9);
        chk("t2_idx", 32'(slot_idx), 1);
        step(23);
        chk("t2_rises", 32'(n_rise), 3);
        chk("t2_slots", 32'(n_slot), 4);
        if (rises.size() >= 2) chk("t2_a1", 32'(rises[1]), 31);

        // withheld ack
        halt();
        wr_cfg(1, 6'h29);
        clr();
        slot_len = 12'd10;
        ack_mode = 0;
        en = 1'b1;
        step(25);
        chk("t3_wr", 32'(inj.ts_injection_addr_wr), 1);
        chk("t3_addr", 32'(inj.ts_injection_addr), 5);
        chk("t3_misscnt", 32'(miss_cnt), 2);
        chk("t3_misspulses", 32'(n_miss), 2);
        inj.ts_injection_addr_ack = 1'b1;
        step(1);
        inj.ts_injection_addr_ack = 1'b0;
        chk("t3_wr_drop", 32'(inj.ts_injection_addr_wr), 0);
        step(6);
        chk("t3_wr_next", 32'(inj.ts_injection_addr_wr), 1);
        chk("t3_addr_next", 32'(inj.ts_injection_addr), 2);

        // ack together with next valid boundary
        halt();
        en = 1'b1;
        step(10);
        inj.ts_injection_addr_ack = 1'b1;
        step(1);
        inj.ts_injection_addr_ack = 1'b0;
        chk("t4_wr", 32'(inj.ts_injection_addr_wr), 1);
        chk("t4_addr", 32'(inj.ts_injection_addr), 9);
        chk("t4_misspulse", 32'(miss_p), 0);
        chk("t4_misscnt", 32'(miss_cnt), 2);

        // minimum slot length, full table, same-cycle cfg write
        halt();
        wr_cfg(5, 6'h27);
        slot_len = 12'd1;
        table_len = 6'd0;
        ack_mode = 1;
        en = 1'b1;
        step(20);
        cfg_wr = 1'b1;
        waddr = 5'd5;
        wdata = 6'h2C;
        step(1);
        cfg_wr = 1'b0;
        chk("t5_wr", 32'(inj.ts_injection_addr_wr), 1);
        chk("t5_oldflow", 32'(inj.ts_injection_addr), 7);
        step(104);
        chk("t5_idx31", 32'(slot_idx), 31);
        step(3);
        chk("t5_idx0", 32'(slot_idx), 0);

        // disable mid-request, late ack, restart
        halt();
        slot_len = 12'd10;
        table_len = 6'd4;
        ack_mode = 0;
        en = 1'b1;
        step(3);
        chk("t6_wr_on", 32'(inj.ts_injection_addr_wr), 1);
        en = 1'b0;
        step(1);
        chk("t6_wr_off", 32'(inj.ts_injection_addr_wr), 0);
        inj.ts_injection_addr_ack = 1'b1;
        step(1);
        inj.ts_injection_addr_ack = 1'b0;
        en = 1'b1;
        step(1);
        chk("t6_restart_wr", 32'(inj.ts_injection_addr_wr), 1);
        chk("t6_restart_addr", 32'(inj.ts_injection_addr), 5);
        chk("t6_restart_cyc", 32'(cyc_p), 1);
        ack_mode = 1;
        step(4);

        // asynchronous reset mid-slot
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_wr", 32'(inj.ts_injection_addr_wr), 0);
        chk("t6_rst_idx", 32'(slot_idx), 0);
        chk("t6_rst_miss", 32'(miss_cnt), 0);
        chk("t6_rst_addr", 32'(inj.ts_injection_addr), 0);
        chk("t6_rst_slot", 32'(slot_p), 0);
        step(2);
        rst_n = 1'b1;
        clr();
        step(40);
        chk("t6_tbl_clear", 32'(n_rise), 0);
        chk("t6_slots", 32'(n_slot), 4);

        // randomized phases
        for (int p = 0; p < 10; p++) begin
            halt();
            slot_len = SW'($urandom_range(0, 16));
            table_len = 6'($urandom_range(0, 40));
            ack_mode = 2;
            rnd_cfg = 1;
            en = 1'b1;
            rnd_en = (p % 2 == 1);
            step(300);
            rnd_cfg = 0;
            rnd_en = 0;
            cfg_wr = 1'b0;
        end
        halt();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
